// File: rtl/mem_access_stage.sv
// Memory-access stage: runs one load or store per start over a req/ack data bus,
// returns extended load data and reports misaligned/illegal/timeout faults.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [63:0] load_data
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_funct3;
    logic [2:0]      r_offset;

    logic [2:0]      w_offset;
    logic            w_illegal;
    logic            w_misaligned;
    logic [7:0]      w_size_strb;
    logic [63:0]     w_shifted;
    logic [63:0]     w_ext;

    // Decode the incoming request: legality, alignment and byte-lane mask
    always_comb begin
        w_offset     = addr[2:0];
        w_illegal    = (mem_read && mem_write)
                    || (mem_read && (funct3 == 3'b111))
                    || (mem_write && funct3[2]);
        w_misaligned = 1'b0;
        w_size_strb  = 8'h01;
        case (funct3[1:0])
            2'b00: begin w_misaligned = 1'b0;               w_size_strb = 8'h01; end
            2'b01: begin w_misaligned = w_offset[0];        w_size_strb = 8'h03; end
            2'b10: begin w_misaligned = |w_offset[1:0];     w_size_strb = 8'h0F; end
            default: begin w_misaligned = |w_offset;        w_size_strb = 8'hFF; end
        endcase
    end

    // Extract and extend the addressed field of the returned doubleword
    always_comb begin
        w_shifted = mem_rdata >> {r_offset, 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_ext = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_ext = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_ext = {56'd0, w_shifted[7:0]};
            3'b101:  w_ext = {48'd0, w_shifted[15:0]};
            3'b110:  w_ext = {32'd0, w_shifted[31:0]};
            default: w_ext = w_shifted;
        endcase
    end

    // Access FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_funct3    <= 3'b000;
            r_offset    <= 3'b000;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 64'd0;
            mem_wdata   <= 64'd0;
            mem_wstrb   <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            load_data   <= 64'd0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (!mem_read && !mem_write) begin
                            r_state     <= S_DONE;
                            done        <= 1'b1;
                            fault_cause <= 2'b00;
                        end else if (w_illegal) begin
                            r_state     <= S_FAULT;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= 2'b10;
                        end else if (w_misaligned) begin
                            r_state     <= S_FAULT;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            r_state   <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_addr  <= {addr[63:3], 3'b000};
                            mem_wdata <= mem_write ? (store_data << {w_offset, 3'b000}) : 64'd0;
                            mem_wstrb <= mem_write ? 8'(w_size_strb << w_offset) : 8'h00;
                            r_funct3  <= funct3;
                            r_offset  <= w_offset;
                            r_cnt     <= CW'(1);
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        r_state     <= S_DONE;
                        mem_req     <= 1'b0;
                        done        <= 1'b1;
                        fault_cause <= 2'b00;
                        if (!mem_we) begin
                            load_data <= w_ext;
                        end
                    end else if ((TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT))) begin
                        r_state     <= S_FAULT;
                        mem_req     <= 1'b0;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE, S_FAULT: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with a few hand-written sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [63:0] load_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done), .fault(fault),
        .fault_cause(fault_cause), .load_data(load_data)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sd;
        logic [63:0] rdata;
        int          ack_at;     // REQ cycle (1-based) in which ack is driven; 0 = never
        int          exp_req;    // expected number of cycles mem_req is high
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [63:0] exp_ld;
        logic [63:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  c;
        int  reqs;
        int  lat;
        bit  seen;
        @(negedge clk);
        start = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
        addr = v.addr; store_data = v.sd;
        @(negedge clk);
        start = 1'b0;
        reqs = 0; seen = 1'b0; lat = 0; c = 1;
        while (!seen && c <= 40) begin
            if (done) begin
                seen = 1'b1; lat = c; mem_ack = 1'b0;
            end else begin
                if (mem_req) begin
                    reqs++;
                    chk($sformatf("v%0d_addr", idx), mem_addr, v.exp_addr);
                    chk($sformatf("v%0d_we", idx), 64'(mem_we), 64'(v.exp_we));
                    chk($sformatf("v%0d_wstrb", idx), 64'(mem_wstrb), 64'(v.exp_wstrb));
                    chk($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
                    mem_ack   = (v.ack_at == reqs);
                    mem_rdata = mem_ack ? v.rdata : 64'h5A5A_5A5A_5A5A_5A5A;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        if (!seen) begin
            chk($sformatf("v%0d_done_timeout", idx), 64'd0, 64'd1);
        end else begin
            chk($sformatf("v%0d_fault", idx), 64'(fault), 64'(v.exp_fault));
            chk($sformatf("v%0d_cause", idx), 64'(fault_cause), 64'(v.exp_cause));
            chk($sformatf("v%0d_load_data", idx), load_data, v.exp_ld);
            chk($sformatf("v%0d_req_cycles", idx), 64'(reqs), 64'(v.exp_req));
            chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_req + 1));
            chk($sformatf("v%0d_req_in_done", idx), 64'(mem_req), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
            chk($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int dones;
        //            rd wr  f3     addr                   sd                      rdata                   ack req flt cause  exp_ld                   exp_addr               we  wstrb  wdata
        vecs[0]  = '{1'b1,1'b0,3'b011,64'h1000,             64'h0,                  64'hDEAD_BEEF_CAFE_F00D,3, 3, 1'b0,2'b00,64'hDEAD_BEEF_CAFE_F00D,64'h1000,             1'b0,8'h00,64'h0};
        vecs[1]  = '{1'b1,1'b0,3'b000,64'h2005,             64'h0,                  64'h0000_8000_0000_0000,1, 1, 1'b0,2'b00,64'hFFFF_FFFF_FFFF_FF80,64'h2000,             1'b0,8'h00,64'h0};
        vecs[2]  = '{1'b1,1'b0,3'b100,64'h2005,             64'h0,                  64'h0000_8000_0000_0000,1, 1, 1'b0,2'b00,64'h0000_0000_0000_0080,64'h2000,             1'b0,8'h00,64'h0};
        vecs[3]  = '{1'b0,1'b1,3'b001,64'h3006,             64'h1234,               64'h0,                  1, 1, 1'b0,2'b00,64'h0000_0000_0000_0080,64'h3000,             1'b1,8'hC0,64'h1234_0000_0000_0000};
        vecs[4]  = '{1'b1,1'b0,3'b010,64'h4002,             64'h0,                  64'h0,                  0, 0, 1'b1,2'b01,64'h0000_0000_0000_0080,64'h0,                1'b0,8'h00,64'h0};
        vecs[5]  = '{1'b0,1'b1,3'b100,64'h5000,             64'hFF,                 64'h0,                  0, 0, 1'b1,2'b10,64'h0000_0000_0000_0080,64'h0,                1'b0,8'h00,64'h0};
        vecs[6]  = '{1'b1,1'b1,3'b011,64'h6000,             64'h0,                  64'h0,                  0, 0, 1'b1,2'b10,64'h0000_0000_0000_0080,64'h0,                1'b0,8'h00,64'h0};
        vecs[7]  = '{1'b1,1'b0,3'b001,64'h7002,             64'h0,                  64'h0000_0000_ABCD_0000,2, 2, 1'b0,2'b00,64'hFFFF_FFFF_FFFF_ABCD,64'h7000,             1'b0,8'h00,64'h0};
        vecs[8]  = '{1'b1,1'b0,3'b110,64'h8004,             64'h0,                  64'h89AB_CDEF_0000_0000,1, 1, 1'b0,2'b00,64'h0000_0000_89AB_CDEF,64'h8000,             1'b0,8'h00,64'h0};
        vecs[9]  = '{1'b1,1'b0,3'b010,64'h8004,             64'h0,                  64'h89AB_CDEF_0000_0000,1, 1, 1'b0,2'b00,64'hFFFF_FFFF_89AB_CDEF,64'h8000,             1'b0,8'h00,64'h0};
        vecs[10] = '{1'b0,1'b1,3'b011,64'h9000,             64'h0123_4567_89AB_CDEF,64'h0,                  2, 2, 1'b0,2'b00,64'hFFFF_FFFF_89AB_CDEF,64'h9000,             1'b1,8'hFF,64'h0123_4567_89AB_CDEF};
        vecs[11] = '{1'b0,1'b1,3'b000,64'hA003,             64'hFFFF_FFFF_FFFF_FF5A,64'h0,                  1, 1, 1'b0,2'b00,64'hFFFF_FFFF_89AB_CDEF,64'hA000,             1'b1,8'h08,64'hFFFF_FFFF_5A00_0000};
        vecs[12] = '{1'b1,1'b0,3'b111,64'hA000,             64'h0,                  64'h0,                  0, 0, 1'b1,2'b10,64'hFFFF_FFFF_89AB_CDEF,64'h0,                1'b0,8'h00,64'h0};
        vecs[13] = '{1'b0,1'b0,3'b011,64'hA001,             64'h0,                  64'h0,                  0, 0, 1'b0,2'b00,64'hFFFF_FFFF_89AB_CDEF,64'h0,                1'b0,8'h00,64'h0};
        vecs[14] = '{1'b0,1'b1,3'b011,64'hB004,             64'h0,                  64'h0,                  0, 0, 1'b1,2'b01,64'hFFFF_FFFF_89AB_CDEF,64'h0,                1'b0,8'h00,64'h0};
        vecs[15] = '{1'b1,1'b0,3'b011,64'hC000,             64'h0,                  64'h1111_2222_3333_4444,16,16,1'b0,2'b00,64'h1111_2222_3333_4444,64'hC000,             1'b0,8'h00,64'h0};
        vecs[16] = '{1'b1,1'b0,3'b011,64'hC008,             64'h0,                  64'h0,                  0, 16,1'b1,2'b11,64'h1111_2222_3333_4444,64'hC008,             1'b0,8'h00,64'h0};

        rst = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 64'd0; store_data = 64'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'({fault, fault_cause}), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wbus", 64'({mem_we, mem_wstrb}), 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_load_data", load_data, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // ack on an idle bus must not start anything
        mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ack_%0d", i), 64'({busy, mem_req, done}), 64'd0);
        end
        mem_ack = 1'b0;
        chk("idle_ack_ld", load_data, 64'h1111_2222_3333_4444);

        // start while busy is dropped; exactly one done per accepted start
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011; addr = 64'hD000;
        @(negedge clk);
        start = 1'b1; addr = 64'hE008;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) start = 1'b0;
            if (done) dones++;
            if (mem_req) chk($sformatf("busy_addr_%0d", c), mem_addr, 64'hD000);
            mem_ack   = mem_req && (c == 2);
            mem_rdata = 64'h42;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("busy_done_count", 64'(dones), 64'd1);
        chk("busy_load_data", load_data, 64'h42);

        // reset during REQ cycle 2: bus drops, no done, no result
        start = 1'b1; addr = 64'hF000;
        @(negedge clk);
        start = 1'b0;
        chk("mid_req_c1", 64'(mem_req), 64'd1);
        @(negedge clk);
        chk("mid_req_c2", 64'(mem_req), 64'd1);
        rst = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy || mem_req) dones++;
        end
        chk("mid_rst_quiet", 64'(dones), 64'd0);
        chk("mid_rst_load_data", load_data, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
